// File: rtl/dispatch_credit_admit.sv
// Credit-based admission of a rename bundle into IQ/LDQ/STQ/AL, with a registered hand-off to the backend.
// Lane layout: bit0 SkipIQ, bit1 isLoad, bit2 isStore, rest opaque payload. Optional: DISPATCH_PERF_CNT_EN.
module dispatch_credit_admit #(
   parameter int DISPATCH_WIDTH = 4,
   parameter int ISSUE_WIDTH    = 3,
   parameter int COMMIT_WIDTH   = 4,
   parameter int IQ_SIZE        = 32,
   parameter int LDQ_SIZE       = 16,
   parameter int STQ_SIZE       = 16,
   parameter int AL_SIZE        = 128,
   parameter int PKT_W          = 16
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    flush_i,
   input  logic                                    backendStall_i,
   input  logic                                    bundleValid_i,
   input  logic [DISPATCH_WIDTH-1:0][PKT_W-1:0]    disPacket_i,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]        iqFree_i,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0]       ldqFree_i,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0]       stqFree_i,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0]       alFree_i,
   output logic                                    stall_o,
   output logic                                    dispatchValid_o,
   output logic [DISPATCH_WIDTH-1:0][PKT_W-1:0]    disPacket_o,
   output logic [$clog2(IQ_SIZE+1)-1:0]            iqCredit_o,
   output logic [$clog2(AL_SIZE+1)-1:0]            alCredit_o,
   output logic                                    creditErr_o
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [31:0]                             stallIQCnt_o,
   output logic [31:0]                             stallLSQCnt_o,
   output logic [31:0]                             stallALCnt_o,
   output logic [31:0]                             stallExtCnt_o
`endif
);

   localparam int IQ_W  = $clog2(IQ_SIZE+1);
   localparam int LDQ_W = $clog2(LDQ_SIZE+1);
   localparam int STQ_W = $clog2(STQ_SIZE+1);
   localparam int AL_W  = $clog2(AL_SIZE+1);
   // Wide enough that credit + free never wraps, so overflow is always visible.
   localparam int EW    = $clog2(AL_SIZE + IQ_SIZE + LDQ_SIZE + STQ_SIZE +
                                 ISSUE_WIDTH + COMMIT_WIDTH + DISPATCH_WIDTH + 1) + 1;
   localparam logic [EW-1:0] NEED_AL = EW'(DISPATCH_WIDTH);

   localparam int SKIP_IQ_BIT  = 0;
   localparam int IS_LOAD_BIT  = 1;
   localparam int IS_STORE_BIT = 2;

   function automatic logic [EW:0] sat_credit(input logic [EW-1:0] raw, input logic [EW-1:0] size);
      if (raw > size) return {1'b1, size};
      return {1'b0, raw};
   endfunction

   logic [IQ_W-1:0]  cred_iq_q, cred_iq_d;
   logic [LDQ_W-1:0] cred_ld_q, cred_ld_d;
   logic [STQ_W-1:0] cred_st_q, cred_st_d;
   logic [AL_W-1:0]  cred_al_q, cred_al_d;
   logic             err_q;

   logic [EW-1:0]    need_iq, need_ld, need_st;
   logic             fit_iq, fit_ld, fit_st, fit_al, fits, fire;
   logic [EW-1:0]    raw_iq, raw_ld, raw_st, raw_al;
   logic [EW:0]      sat_iq, sat_ld, sat_st, sat_al;
   logic             any_ovf;
   logic             unused_sat_hi;

   logic                                 vld_p1;
   logic [DISPATCH_WIDTH-1:0][PKT_W-1:0] pkt_p1;

   always_comb begin
      need_iq = '0;
      need_ld = '0;
      need_st = '0;
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
         need_iq = need_iq + EW'(!disPacket_i[l][SKIP_IQ_BIT]);
         need_ld = need_ld + EW'(disPacket_i[l][IS_LOAD_BIT]);
         need_st = need_st + EW'(disPacket_i[l][IS_STORE_BIT]);
      end
   end

   // Admission looks only at registered credits; this cycle's frees land next cycle.
   assign fit_iq  = EW'(cred_iq_q) >= need_iq;
   assign fit_ld  = EW'(cred_ld_q) >= need_ld;
   assign fit_st  = EW'(cred_st_q) >= need_st;
   assign fit_al  = EW'(cred_al_q) >= NEED_AL;
   assign fits    = fit_iq & fit_ld & fit_st & fit_al;
   assign fire    = bundleValid_i & fits & ~backendStall_i & ~flush_i;
   assign stall_o = bundleValid_i & ~fire & ~flush_i;

   always_comb begin
      raw_iq = EW'(cred_iq_q) - (fire ? need_iq : '0) + EW'(iqFree_i);
      raw_ld = EW'(cred_ld_q) - (fire ? need_ld : '0) + EW'(ldqFree_i);
      raw_st = EW'(cred_st_q) - (fire ? need_st : '0) + EW'(stqFree_i);
      raw_al = EW'(cred_al_q) - (fire ? NEED_AL : '0) + EW'(alFree_i);
      sat_iq = sat_credit(raw_iq, EW'(IQ_SIZE));
      sat_ld = sat_credit(raw_ld, EW'(LDQ_SIZE));
      sat_st = sat_credit(raw_st, EW'(STQ_SIZE));
      sat_al = sat_credit(raw_al, EW'(AL_SIZE));
      cred_iq_d = sat_iq[IQ_W-1:0];
      cred_ld_d = sat_ld[LDQ_W-1:0];
      cred_st_d = sat_st[STQ_W-1:0];
      cred_al_d = sat_al[AL_W-1:0];
      any_ovf   = sat_iq[EW] | sat_ld[EW] | sat_st[EW] | sat_al[EW];
   end

   // Saturated values never exceed SIZE, so these high bits are always zero.
   assign unused_sat_hi = ^{sat_iq[EW-1:IQ_W], sat_ld[EW-1:LDQ_W],
                            sat_st[EW-1:STQ_W], sat_al[EW-1:AL_W]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cred_iq_q <= IQ_W'(IQ_SIZE);
         cred_ld_q <= LDQ_W'(LDQ_SIZE);
         cred_st_q <= STQ_W'(STQ_SIZE);
         cred_al_q <= AL_W'(AL_SIZE);
         err_q     <= 1'b0;
      end else if (flush_i) begin
         cred_iq_q <= IQ_W'(IQ_SIZE);
         cred_ld_q <= LDQ_W'(LDQ_SIZE);
         cred_st_q <= STQ_W'(STQ_SIZE);
         cred_al_q <= AL_W'(AL_SIZE);
      end else begin
         cred_iq_q <= cred_iq_d;
         cred_ld_q <= cred_ld_d;
         cred_st_q <= cred_st_d;
         cred_al_q <= cred_al_d;
         err_q     <= err_q | any_ovf;
      end
   end

   // p1: admitted bundle toward the backend
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         pkt_p1 <= '0;
      end else begin
         vld_p1 <= fire;
         if (fire) pkt_p1 <= disPacket_i;
      end
   end

   assign dispatchValid_o = vld_p1;
   assign disPacket_o     = pkt_p1;
   assign iqCredit_o      = cred_iq_q;
   assign alCredit_o      = cred_al_q;
   assign creditErr_o     = err_q;

`ifdef DISPATCH_PERF_CNT_EN
   // Stall cause attribution order: AL, then IQ, then LDQ/STQ, else external hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallIQCnt_o  <= '0;
         stallLSQCnt_o <= '0;
         stallALCnt_o  <= '0;
         stallExtCnt_o <= '0;
      end else if (flush_i) begin
         stallIQCnt_o  <= '0;
         stallLSQCnt_o <= '0;
         stallALCnt_o  <= '0;
         stallExtCnt_o <= '0;
      end else if (stall_o) begin
         if (!fit_al)                stallALCnt_o  <= stallALCnt_o + 32'd1;
         else if (!fit_iq)           stallIQCnt_o  <= stallIQCnt_o + 32'd1;
         else if (!fit_ld || !fit_st) stallLSQCnt_o <= stallLSQCnt_o + 32'd1;
         else                        stallExtCnt_o <= stallExtCnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dispatch_credit_admit.sv
// Randomised and directed bench for dispatch_credit_admit against a queue-occupancy reference model.
module tb_dispatch_credit_admit;
   localparam int DW = 4, PW = 16;
   localparam int IQS = 32, LQS = 16, SQS = 16, ALS = 128;
   typedef logic [DW-1:0][PW-1:0] bundle_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, flush_i, backendStall_i, bundleValid_i;
   bundle_t       disPacket_i, disPacket_o;
   logic [1:0]    iqFree_i;
   logic [2:0]    ldqFree_i, stqFree_i, alFree_i;
   logic          stall_o, dispatchValid_o, creditErr_o;
   logic [5:0]    iqCredit_o;
   logic [7:0]    alCredit_o;
`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0]   cnt_iq, cnt_lsq, cnt_al, cnt_ext;
`endif

   dispatch_credit_admit dut (
      .clk(clk), .reset(reset), .flush_i(flush_i), .backendStall_i(backendStall_i),
      .bundleValid_i(bundleValid_i), .disPacket_i(disPacket_i),
      .iqFree_i(iqFree_i), .ldqFree_i(ldqFree_i), .stqFree_i(stqFree_i), .alFree_i(alFree_i),
      .stall_o(stall_o), .dispatchValid_o(dispatchValid_o), .disPacket_o(disPacket_o),
      .iqCredit_o(iqCredit_o), .alCredit_o(alCredit_o), .creditErr_o(creditErr_o)
`ifdef DISPATCH_PERF_CNT_EN
      , .stallIQCnt_o(cnt_iq), .stallLSQCnt_o(cnt_lsq), .stallALCnt_o(cnt_al), .stallExtCnt_o(cnt_ext)
`endif
   );

   int checks = 0, failures = 0;
   // Reference: free entries remaining in each backend structure.
   int      m_iq, m_ld, m_st, m_al;
   bit      m_err, m_vld;
   bundle_t m_pkt;
   bit      exp_stall, obs_stall;

   function automatic logic [PW-1:0] lane(input bit skip, input bit ld, input bit st);
      logic [PW-4:0] pay;
      pay = (PW-3)'($urandom);
      return {pay, st, ld, skip};
   endfunction

   function automatic int count_bit(input bundle_t p, input int b);
      int n = 0;
      for (int l = 0; l < DW; l++) n += int'(p[l][b]);
      return n;
   endfunction

   function automatic bundle_t alu_bundle();
      bundle_t p;
      for (int l = 0; l < DW; l++) p[l] = lane(1'b0, 1'b0, 1'b0);
      return p;
   endfunction

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_iq = IQS; m_ld = LQS; m_st = SQS; m_al = ALS;
      m_err = 0; m_vld = 0; m_pkt = '0;
   endtask

   task automatic step(input bit v, input bit bs, input bit fl, input bundle_t p,
                       input int fiq, input int fld, input int fst, input int fal);
      int niq, nld, nst;
      bit fire;
      @(negedge clk);
      bundleValid_i = v; backendStall_i = bs; flush_i = fl; disPacket_i = p;
      iqFree_i = 2'(fiq); ldqFree_i = 3'(fld); stqFree_i = 3'(fst); alFree_i = 3'(fal);
      niq = DW - count_bit(p, 0);
      nld = count_bit(p, 1);
      nst = count_bit(p, 2);
      fire = v && !bs && !fl && m_iq >= niq && m_ld >= nld && m_st >= nst && m_al >= DW;
      exp_stall = v && !fire && !fl;
      #1 obs_stall = stall_o;
      @(posedge clk);
      if (fl) begin
         m_iq = IQS; m_ld = LQS; m_st = SQS; m_al = ALS; m_vld = 0;
      end else begin
         m_iq = m_iq - (fire ? niq : 0) + fiq;
         m_ld = m_ld - (fire ? nld : 0) + fld;
         m_st = m_st - (fire ? nst : 0) + fst;
         m_al = m_al - (fire ? DW : 0) + fal;
         if (m_iq > IQS) begin m_iq = IQS; m_err = 1; end
         if (m_ld > LQS) begin m_ld = LQS; m_err = 1; end
         if (m_st > SQS) begin m_st = SQS; m_err = 1; end
         if (m_al > ALS) begin m_al = ALS; m_err = 1; end
         m_vld = fire;
         if (fire) m_pkt = p;
      end
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; flush_i = 0; backendStall_i = 0; bundleValid_i = 0; disPacket_i = '0;
      iqFree_i = 0; ldqFree_i = 0; stqFree_i = 0; alFree_i = 0;
      model_reset();
      @(negedge clk); #1;
      checks++; if (iqCredit_o !== 6'd32) begin failures++; $display("FAIL reset_iq got=%0d exp=32", iqCredit_o); end
      checks++; if (alCredit_o !== 8'd128) begin failures++; $display("FAIL reset_al got=%0d exp=128", alCredit_o); end
      checks++; if (dispatchValid_o !== 1'b0 || creditErr_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL reset_ctl vld=%b err=%b stall=%b exp=000", dispatchValid_o, creditErr_o, stall_o); end
      checks++; if (disPacket_o !== '0) begin failures++; $display("FAIL reset_pkt got=%h exp=0", disPacket_o); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_fill_iq();
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, alu_bundle(), 0, 0, 0, 0);
         checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL fill_stall i=%0d got=%b exp=%b", i, obs_stall, exp_stall); end
         checks++; if (dispatchValid_o !== m_vld || disPacket_o !== m_pkt) begin failures++; $display("FAIL fill_out i=%0d vld=%b exp=%b pkt=%h exp=%h", i, dispatchValid_o, m_vld, disPacket_o, m_pkt); end
         checks++; if (iqCredit_o !== 6'(m_iq)) begin failures++; $display("FAIL fill_iq i=%0d got=%0d exp=%0d", i, iqCredit_o, m_iq); end
      end
      checks++; if (iqCredit_o !== 6'd0 || alCredit_o !== 8'd96) begin failures++; $display("FAIL fill_end iq=%0d exp=0 al=%0d exp=96", iqCredit_o, alCredit_o); end
      step(1, 0, 0, alu_bundle(), 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1 || dispatchValid_o !== 1'b0) begin failures++; $display("FAIL fill_9th stall=%b exp=1 vld=%b exp=0", obs_stall, dispatchValid_o); end
   endtask

   task automatic test_iq_free_stall();
      bundle_t p = alu_bundle();
      int fr[4] = '{3, 0, 1, 0};
      bit st[4] = '{1, 1, 1, 0};
      int cr[4] = '{3, 3, 4, 0};
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, p, fr[i], 0, 0, 0);
         checks++; if (obs_stall !== st[i] || obs_stall !== exp_stall) begin failures++; $display("FAIL ifree_stall i=%0d got=%b exp=%b", i, obs_stall, st[i]); end
         checks++; if (iqCredit_o !== 6'(cr[i]) || iqCredit_o !== 6'(m_iq)) begin failures++; $display("FAIL ifree_iq i=%0d got=%0d exp=%0d", i, iqCredit_o, cr[i]); end
      end
      checks++; if (dispatchValid_o !== 1'b1 || disPacket_o !== p) begin failures++; $display("FAIL ifree_admit vld=%b pkt=%h exp=%h", dispatchValid_o, disPacket_o, p); end
   endtask

   task automatic test_exact_fit();
      bundle_t p;
      step(0, 0, 0, '0, 2, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0 || iqCredit_o !== 6'd2) begin failures++; $display("FAIL exact_idle stall=%b exp=0 iq=%0d exp=2", obs_stall, iqCredit_o); end
      p = {lane(1, 0, 0), lane(0, 0, 0), lane(1, 0, 0), lane(0, 0, 0)};
      step(1, 0, 0, p, 1, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0 || dispatchValid_o !== 1'b1) begin failures++; $display("FAIL exact_admit stall=%b exp=0 vld=%b exp=1", obs_stall, dispatchValid_o); end
      checks++; if (iqCredit_o !== 6'd1 || alCredit_o !== 8'(m_al)) begin failures++; $display("FAIL exact_cred iq=%0d exp=1 al=%0d exp=%0d", iqCredit_o, alCredit_o, m_al); end
   endtask

   task automatic test_lsq();
      bundle_t ld4 = {lane(1, 1, 0), lane(1, 1, 0), lane(1, 1, 0), lane(1, 1, 0)};
      bundle_t ld2 = {lane(1, 1, 0), lane(1, 0, 0), lane(1, 1, 0), lane(1, 0, 0)};
      bundle_t mix = {lane(1, 1, 0), lane(1, 0, 1), lane(1, 1, 0), lane(1, 1, 0)};
      bundle_t ld1 = {lane(1, 0, 0), lane(1, 0, 0), lane(1, 1, 0), lane(1, 0, 0)};
      bundle_t st1 = {lane(1, 0, 1), lane(1, 0, 0), lane(1, 0, 0), lane(1, 0, 0)};
      bundle_t seq[8] = '{ld4, ld4, ld4, ld2, mix, mix, mix, ld1};
      int lfr[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      bit st[8] = '{0, 0, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, seq[i], 0, lfr[i], 0, 0);
         checks++; if (obs_stall !== st[i] || obs_stall !== exp_stall) begin failures++; $display("FAIL lsq_stall i=%0d got=%b exp=%b", i, obs_stall, st[i]); end
         checks++; if (dispatchValid_o !== m_vld || alCredit_o !== 8'(m_al)) begin failures++; $display("FAIL lsq_out i=%0d vld=%b exp=%b al=%0d exp=%0d", i, dispatchValid_o, m_vld, alCredit_o, m_al); end
      end
      step(1, 0, 0, st1, 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0 || dispatchValid_o !== 1'b1 || disPacket_o !== st1) begin failures++; $display("FAIL lsq_store stall=%b exp=0 vld=%b exp=1", obs_stall, dispatchValid_o); end
   endtask

   task automatic test_flush();
      bundle_t p = {lane(1, 0, 0), lane(1, 1, 0), lane(1, 0, 0), lane(1, 0, 0)};
      step(0, 0, 0, '0, 3, 0, 0, 0);
      step(0, 0, 0, '0, 1, 0, 0, 0);
      step(1, 0, 0, p, 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1 || iqCredit_o !== 6'd5) begin failures++; $display("FAIL flush_pre stall=%b exp=1 iq=%0d exp=5", obs_stall, iqCredit_o); end
      step(1, 0, 1, p, 1, 2, 1, 3);
      checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", obs_stall); end
      checks++; if (iqCredit_o !== 6'd32 || alCredit_o !== 8'd128 || dispatchValid_o !== 1'b0 || creditErr_o !== 1'b0) begin failures++; $display("FAIL flush_state iq=%0d al=%0d vld=%b err=%b exp=32,128,0,0", iqCredit_o, alCredit_o, dispatchValid_o, creditErr_o); end
      step(1, 0, 0, p, 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0 || dispatchValid_o !== 1'b1) begin failures++; $display("FAIL flush_after stall=%b exp=0 vld=%b exp=1", obs_stall, dispatchValid_o); end
   endtask

   task automatic test_overflow_err();
      step(0, 0, 0, '0, 1, 0, 0, 0);
      checks++; if (iqCredit_o !== 6'd32 || creditErr_o !== 1'b1) begin failures++; $display("FAIL ovf_set iq=%0d exp=32 err=%b exp=1", iqCredit_o, creditErr_o); end
      step(0, 0, 0, '0, 0, 0, 0, 0);
      step(0, 0, 1, '0, 0, 0, 0, 0);
      checks++; if (creditErr_o !== 1'b1 || creditErr_o !== m_err) begin failures++; $display("FAIL ovf_sticky err=%b exp=1", creditErr_o); end
   endtask

   task automatic test_async_reset();
      step(1, 0, 0, alu_bundle(), 0, 0, 0, 0);
      step(1, 1, 0, alu_bundle(), 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1 || iqCredit_o !== 6'd28) begin failures++; $display("FAIL areset_pre stall=%b exp=1 iq=%0d exp=28", obs_stall, iqCredit_o); end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++; if (iqCredit_o !== 6'd32 || alCredit_o !== 8'd128 || creditErr_o !== 1'b0) begin failures++; $display("FAIL areset_cred iq=%0d al=%0d err=%b exp=32,128,0", iqCredit_o, alCredit_o, creditErr_o); end
      checks++; if (dispatchValid_o !== 1'b0 || disPacket_o !== '0) begin failures++; $display("FAIL areset_out vld=%b pkt=%h exp=0", dispatchValid_o, disPacket_o); end
      @(negedge clk);
      reset = 1'b1;
      bundleValid_i = 0; backendStall_i = 0;
   endtask

   task automatic test_random();
      bundle_t p;
      bit v, bs, fl;
      for (int c = 0; c < 400; c++) begin
         for (int l = 0; l < DW; l++) begin
            int r = $urandom_range(0, 3);
            p[l] = lane(1'($urandom_range(0, 1)), r == 0, r == 1);
         end
         v  = ($urandom_range(0, 3) != 0);
         bs = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 31) == 0);
         step(v, bs, fl, p,
              $urandom_range(0, min2(3, IQS - m_iq)), $urandom_range(0, min2(4, LQS - m_ld)),
              $urandom_range(0, min2(4, SQS - m_st)), $urandom_range(0, min2(4, ALS - m_al)));
         checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, obs_stall, exp_stall); end
         checks++; if (dispatchValid_o !== m_vld || disPacket_o !== m_pkt) begin failures++; $display("FAIL rand_out c=%0d vld=%b exp=%b pkt=%h exp=%h", c, dispatchValid_o, m_vld, disPacket_o, m_pkt); end
         checks++; if (iqCredit_o !== 6'(m_iq) || alCredit_o !== 8'(m_al) || creditErr_o !== m_err) begin failures++; $display("FAIL rand_cred c=%0d iq=%0d exp=%0d al=%0d exp=%0d err=%b exp=%b", c, iqCredit_o, m_iq, alCredit_o, m_al, creditErr_o, m_err); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill_iq();
      test_iq_free_stall();
      test_exact_fit();
      test_lsq();
      test_flush();
      test_overflow_err();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
